// File: rtl/sram_pkg.sv
// sram_pkg: shared state type, width defaults and byte-merge helper for the 1RW1R masked SRAM
package sram_pkg;
  typedef enum logic {CLEAR, IDLE} state_e;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_ADDR_WIDTH  = 5;
  localparam int MAX_DATA_WIDTH  = 256;
  localparam int MAX_WMASK_WIDTH = MAX_DATA_WIDTH / 8;
  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
    input logic [MAX_DATA_WIDTH-1:0]  old_w,
    input logic [MAX_DATA_WIDTH-1:0]  new_w,
    input logic [MAX_WMASK_WIDTH-1:0] mask
  );
    logic [MAX_DATA_WIDTH-1:0] m;
    for (int i = 0; i < MAX_WMASK_WIDTH; i++) m[8*i+:8] = mask[i] ? new_w[8*i+:8] : old_w[8*i+:8];
    return m;
  endfunction
endpackage

// File: rtl/sram_clear_ctrl.sv
// sram_clear_ctrl: post-reset array clear sequencer; drives clear_en_o/clear_addr_o and ready_o
module sram_clear_ctrl import sram_pkg::*; #(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int RAM_DEPTH      = 1 << ADDR_WIDTH,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  clear_en_o,
  output logic [ADDR_WIDTH-1:0] clear_addr_o,
  output logic                  ready_o
);
  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  clear_en_q;
  logic [ADDR_WIDTH-1:0] clear_addr_q;
  logic                  ready_q;
  // The last clear address is issued on the same edge that raises ready, so ready
  // rises on the RAM_DEPTH-th posedge and the final word is zeroed on the next negedge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      cnt_q        <= '0;
      clear_en_q   <= 1'b0;
      clear_addr_q <= '0;
      ready_q      <= (CLEAR_ON_RESET == 0);
    end else if (state_q == CLEAR) begin
      clear_en_q   <= 1'b1;
      clear_addr_q <= cnt_q;
      cnt_q        <= cnt_q + ADDR_WIDTH'(1);
      if (cnt_q == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
        state_q <= IDLE;
        ready_q <= 1'b1;
      end
    end else begin
      clear_en_q <= 1'b0;
    end
  end
  assign clear_en_o   = clear_en_q;
  assign clear_addr_o = clear_addr_q;
  assign ready_o      = ready_q;
endmodule

// File: rtl/sram_1rw1r_mask.sv
// sram_1rw1r_mask: 1RW+1R SRAM model, byte write mask, optional post-reset clear, posedge capture / negedge access
module sram_1rw1r_mask import sram_pkg::*; #(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int RAM_DEPTH      = 1 << ADDR_WIDTH,
  parameter int WMASK_WIDTH    = DATA_WIDTH / 8,
  parameter int CLEAR_ON_RESET = 1,
  parameter int DELAY          = 0
) (
  input  logic                   clk0,
  input  logic                   rstb0,
  input  logic                   csb0,
  input  logic                   web0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  output logic [DATA_WIDTH-1:0]  dout0,
  input  logic                   csb1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  output logic [DATA_WIDTH-1:0]  dout1,
  output logic                   ready0
);
  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
    $error("sram_1rw1r_mask: DATA_WIDTH must be a multiple of 8 and <= MAX_DATA_WIDTH");
  end
  // DELAY only shapes behavioural-model timing; this RTL updates dout with zero delay.
  if (DELAY < 0) begin : g_bad_delay
    $error("sram_1rw1r_mask: DELAY must be non-negative");
  end
  logic [DATA_WIDTH-1:0]  mem [RAM_DEPTH];
  logic                   clear_en;
  logic [ADDR_WIDTH-1:0]  clear_addr;
  logic                   csb0_d, csb1_d;
  logic                   csb0_q, web0_q, csb1_q;
  logic [WMASK_WIDTH-1:0] wmask0_q;
  logic [ADDR_WIDTH-1:0]  addr0_q, addr1_q;
  logic [DATA_WIDTH-1:0]  din0_q, dout0_q, dout1_q;
  logic                   wr0, rd0, rd1;
  logic [DATA_WIDTH-1:0]  wdata;
  sram_clear_ctrl #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .RAM_DEPTH     (RAM_DEPTH),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clear (
    .clk_i       (clk0),
    .rst_ni      (rstb0),
    .clear_en_o  (clear_en),
    .clear_addr_o(clear_addr),
    .ready_o     (ready0)
  );
  // Requests arriving while not ready are dropped by forcing the captured selects high.
  always_comb begin
    csb0_d = ready0 ? csb0 : 1'b1;
    csb1_d = ready0 ? csb1 : 1'b1;
  end
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      csb0_q   <= 1'b1;
      csb1_q   <= 1'b1;
      web0_q   <= 1'b0;
      wmask0_q <= '0;
      addr0_q  <= '0;
      addr1_q  <= '0;
      din0_q   <= '0;
    end else begin
      csb0_q   <= csb0_d;
      csb1_q   <= csb1_d;
      web0_q   <= web0;
      wmask0_q <= wmask0;
      addr0_q  <= addr0;
      addr1_q  <= addr1;
      din0_q   <= din0;
    end
  end
  assign wr0 = !csb0_q && !web0_q;
  assign rd0 = !csb0_q && web0_q;
  assign rd1 = !csb1_q;
  // Merged word feeds both the array and write-first forwarding to port 1.
  assign wdata = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(mem[addr0_q]), MAX_DATA_WIDTH'(din0_q),
                                        MAX_WMASK_WIDTH'(wmask0_q)));
  always_ff @(negedge clk0) begin
    if (clear_en) mem[clear_addr] <= '0;
    if (wr0) mem[addr0_q] <= wdata;
  end
  always_ff @(negedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      dout0_q <= '0;
      dout1_q <= '0;
    end else begin
      if (rd0) dout0_q <= mem[addr0_q];
      if (rd1) dout1_q <= (wr0 && addr0_q == addr1_q) ? wdata : mem[addr1_q];
    end
  end
  assign dout0 = dout0_q;
  assign dout1 = dout1_q;
`ifdef SRAM_TRACE
  always @(negedge clk0) begin
    if (wr0) $display("sram write a=%0d d=%h m=%b", addr0_q, din0_q, wmask0_q);
    if (rd0) $display("sram read0 a=%0d d=%h", addr0_q, mem[addr0_q]);
    if (rd1) $display("sram read1 a=%0d d=%h", addr1_q, mem[addr1_q]);
  end
`endif
endmodule

// File: tb/tb_sram_1rw1r_mask.sv
// tb_sram_1rw1r_mask: directed self-checking bench for sram_1rw1r_mask, clear and no-clear variants
module tb_sram_1rw1r_mask;
  logic        clk0 = 1'b0;
  logic        rstb_c, rstb_n;
  logic        csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [4:0]  addr0, addr1;
  logic [31:0] din0;
  logic [31:0] dout0_c, dout1_c, dout0_n, dout1_n;
  logic        ready_c, ready_n;
  int          checks = 0;
  int          errors = 0;
  always #5 clk0 = ~clk0;
  sram_1rw1r_mask #(.CLEAR_ON_RESET(1)) u_clr (
    .clk0(clk0), .rstb0(rstb_c), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(dout0_c), .csb1(csb1), .addr1(addr1), .dout1(dout1_c), .ready0(ready_c)
  );
  sram_1rw1r_mask #(.CLEAR_ON_RESET(0)) u_nclr (
    .clk0(clk0), .rstb0(rstb_n), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(dout0_n), .csb1(csb1), .addr1(addr1), .dout1(dout1_n), .ready0(ready_n)
  );
  task automatic cyc();
    @(posedge clk0);
    #1;
  endtask
  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'h0; csb1 = 1'b1;
  endtask
  task automatic p0_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
  endtask
  task automatic p0_read(input logic [4:0] a);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a;
  endtask
  task automatic p1_read(input logic [4:0] a);
    csb1 = 1'b0; addr1 = a;
  endtask
  // Issue the driven request at the next posedge, then idle; dout is settled on return.
  task automatic finish_req();
    cyc();
    idle();
    cyc();
  endtask
  task automatic test_reset();
    rstb_c = 1'b0; rstb_n = 1'b0; idle(); addr0 = '0; addr1 = '0; din0 = '0;
    cyc(); cyc();
    checks++; if (ready_c !== 1'b0) begin errors++; $display("FAIL reset_ready_clr: got %b expected 0", ready_c); end
    checks++; if (dout0_c !== 32'h0) begin errors++; $display("FAIL reset_dout0: got %h expected 00000000", dout0_c); end
    checks++; if (dout1_c !== 32'h0) begin errors++; $display("FAIL reset_dout1: got %h expected 00000000", dout1_c); end
    checks++; if (ready_n !== 1'b1) begin errors++; $display("FAIL reset_ready_noclr: got %b expected 1", ready_n); end
  endtask
  task automatic test_clear();
    rstb_c = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      cyc();
      checks++;
      if (ready_c !== (k == 32)) begin errors++; $display("FAIL clear_ready posedge %0d: got %b expected %b", k, ready_c, k == 32); end
    end
    for (int a = 0; a < 32; a++) begin
      p1_read(5'(a));
      finish_req();
      checks++; if (dout1_c !== 32'h0) begin errors++; $display("FAIL clear_read addr %0d: got %h expected 00000000", a, dout1_c); end
    end
  endtask
  task automatic test_byte_mask();
    p0_write(5'd5, 32'hAABBCCDD, 4'hF); cyc();
    p0_write(5'd5, 32'h11223344, 4'b0101); cyc();
    p0_read(5'd5); finish_req();
    checks++; if (dout0_c !== 32'hAA22CC44) begin errors++; $display("FAIL mask_read: got %h expected aa22cc44", dout0_c); end
    p0_write(5'd5, 32'h0, 4'h0); finish_req();
    checks++; if (dout0_c !== 32'hAA22CC44) begin errors++; $display("FAIL write_hold_dout0: got %h expected aa22cc44", dout0_c); end
    p0_read(5'd5); p1_read(5'd5); finish_req();
    checks++; if (dout0_c !== 32'hAA22CC44) begin errors++; $display("FAIL mask_zero_noop: got %h expected aa22cc44", dout0_c); end
    checks++; if (dout1_c !== 32'hAA22CC44) begin errors++; $display("FAIL mask_read_p1: got %h expected aa22cc44", dout1_c); end
  endtask
  task automatic test_collision();
    p0_write(5'd3, 32'hDEADBEEF, 4'hF); p1_read(5'd3); finish_req();
    checks++; if (dout1_c !== 32'hDEADBEEF) begin errors++; $display("FAIL collision_full: got %h expected deadbeef", dout1_c); end
    p0_read(5'd3); p1_read(5'd3); finish_req();
    checks++; if (dout0_c !== 32'hDEADBEEF) begin errors++; $display("FAIL dual_read_p0: got %h expected deadbeef", dout0_c); end
    checks++; if (dout1_c !== 32'hDEADBEEF) begin errors++; $display("FAIL dual_read_p1: got %h expected deadbeef", dout1_c); end
    p0_write(5'd3, 32'h0, 4'b0011); p1_read(5'd3); finish_req();
    checks++; if (dout1_c !== 32'hDEAD0000) begin errors++; $display("FAIL collision_merge: got %h expected dead0000", dout1_c); end
  endtask
  task automatic test_hold();
    p0_read(5'd5); p1_read(5'd5); finish_req();
    checks++; if (dout0_c !== 32'hAA22CC44) begin errors++; $display("FAIL hold_pre_p0: got %h expected aa22cc44", dout0_c); end
    checks++; if (dout1_c !== 32'hAA22CC44) begin errors++; $display("FAIL hold_pre_p1: got %h expected aa22cc44", dout1_c); end
    addr0 = 5'd3; addr1 = 5'd3; web0 = 1'b1; din0 = 32'h55555555;
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++; if (dout0_c !== 32'hAA22CC44) begin errors++; $display("FAIL hold_p0 cycle %0d: got %h expected aa22cc44", k, dout0_c); end
      checks++; if (dout1_c !== 32'hAA22CC44) begin errors++; $display("FAIL hold_p1 cycle %0d: got %h expected aa22cc44", k, dout1_c); end
    end
  endtask
  task automatic test_reset_mid_clear();
    rstb_c = 1'b0; cyc();
    rstb_c = 1'b1;
    for (int k = 0; k < 10; k++) cyc();
    rstb_c = 1'b0; cyc();
    rstb_c = 1'b1;
    p0_write(5'd7, 32'hFFFFFFFF, 4'hF); p1_read(5'd5);
    for (int k = 1; k <= 32; k++) begin
      cyc();
      checks++;
      if (ready_c !== (k == 32)) begin errors++; $display("FAIL midclr_ready posedge %0d: got %b expected %b", k, ready_c, k == 32); end
    end
    idle();
    checks++; if (dout1_c !== 32'h0) begin errors++; $display("FAIL midclr_dropped_read: got %h expected 00000000", dout1_c); end
    p0_write(5'd9, 32'h5A5A5A5A, 4'hF); cyc();
    p0_read(5'd9); p1_read(5'd9); finish_req();
    checks++; if (dout0_c !== 32'h5A5A5A5A) begin errors++; $display("FAIL midclr_rd9_p0: got %h expected 5a5a5a5a", dout0_c); end
    checks++; if (dout1_c !== 32'h5A5A5A5A) begin errors++; $display("FAIL midclr_rd9_p1: got %h expected 5a5a5a5a", dout1_c); end
    p0_read(5'd5); p1_read(5'd7); finish_req();
    checks++; if (dout0_c !== 32'h0) begin errors++; $display("FAIL midclr_addr5_cleared: got %h expected 00000000", dout0_c); end
    checks++; if (dout1_c !== 32'h0) begin errors++; $display("FAIL midclr_addr7_untouched: got %h expected 00000000", dout1_c); end
  endtask
  task automatic test_no_clear();
    checks++; if (ready_n !== 1'b1) begin errors++; $display("FAIL noclr_ready_in_reset: got %b expected 1", ready_n); end
    p0_write(5'd31, 32'h12345678, 4'hF);
    rstb_n = 1'b1;
    #1;
    checks++; if (ready_n !== 1'b1) begin errors++; $display("FAIL noclr_ready_after_release: got %b expected 1", ready_n); end
    cyc();
    p0_read(5'd31); finish_req();
    checks++; if (dout0_n !== 32'h12345678) begin errors++; $display("FAIL noclr_readback: got %h expected 12345678", dout0_n); end
  endtask
  initial begin
    test_reset();
    test_clear();
    test_byte_mask();
    test_collision();
    test_hold();
    test_reset_mid_clear();
    test_no_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
